// File: rtl/adc_share_sched.sv
// adc_share_sched: round-robin scheduler that time-shares one flash ADC
// among N_CH requesters. Each conversion runs through mux select, settle,
// sample/hold and convert. The 7-bit thermometer is then decoded and the
// result is returned over a valid/ready handshake.
module adc_share_sched #(
  parameter int N_CH       = 4,
  parameter int SETTLE_CYC = 3,
  parameter int CONV_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         gnt,
  output logic [$clog2(N_CH)-1:0] ch_sel,
  output logic                    sample,
  output logic                    busy,
  input  logic [6:0]              therm,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(N_CH)-1:0] rsp_ch,
  output logic [2:0]              rsp_code,
  output logic                    rsp_err
);

  localparam int CH_W    = $clog2(N_CH);
  localparam int MAX_CYC = (SETTLE_CYC > CONV_CYC) ? SETTLE_CYC : CONV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_SAMPLE  = 3'd2,
    S_CONVERT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [CH_W-1:0]     rsp_ch_q, rsp_ch_d;
  logic [2:0]          rsp_code_q, rsp_code_d;
  logic                rsp_err_q, rsp_err_d;

  logic                found;
  logic [CH_W-1:0]     win;
  logic [CH_W-1:0]     idx_c;

  // Number of comparators that fired; at most 7, so it never overflows 3 bits.
  function automatic logic [2:0] therm_popcount(input logic [6:0] t);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      c = c + {2'b00, t[i]};
    end
    return c;
  endfunction

  // A legal thermometer is a run of ones starting at bit 0. Adding one to
  // such a run yields a single bit just above it, so the AND is zero.
  function automatic logic therm_bubble(input logic [6:0] t);
    return (t & (t + 7'd1)) != 7'd0;
  endfunction

  // Round-robin search: first set request at or above the pointer, with wrap.
  always_comb begin
    int idx;
    idx   = 0;
    idx_c = '0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_c = CH_W'(idx);
      if (!found && req[idx_c]) begin
        found = 1'b1;
        win   = idx_c;
      end
    end
  end

  // Next-state, counter, grant and result-capture logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    ch_sel_d   = ch_sel_q;
    gnt_d      = '0;
    rsp_ch_d   = rsp_ch_q;
    rsp_code_d = rsp_code_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d  = S_SETTLE;
          ch_sel_d = win;
          gnt_d    = {{(N_CH-1){1'b0}}, 1'b1} << win;
          cnt_d    = CNT_W'(SETTLE_CYC - 1);
          ptr_d    = (win == CH_W'(N_CH - 1)) ? '0 : win + CH_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SAMPLE: begin
        state_d = S_CONVERT;
        cnt_d   = CNT_W'(CONV_CYC - 1);
      end
      S_CONVERT: begin
        if (cnt_q == '0) begin
          state_d    = S_DONE;
          rsp_ch_d   = ch_sel_q;
          rsp_code_d = therm_popcount(therm);
          rsp_err_d  = therm_bubble(therm);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // The transfer cycle only returns to IDLE; arbitration happens there.
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      ch_sel_q   <= '0;
      gnt_q      <= '0;
      rsp_ch_q   <= '0;
      rsp_code_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      ch_sel_q   <= ch_sel_d;
      gnt_q      <= gnt_d;
      rsp_ch_q   <= rsp_ch_d;
      rsp_code_q <= rsp_code_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign gnt       = gnt_q;
  assign ch_sel    = ch_sel_q;
  assign sample    = (state_q == S_SAMPLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_ch    = rsp_ch_q;
  assign rsp_code  = rsp_code_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: doc/adc_share_sched.md
Name: adc_share_sched

Overview:
- Round-robin scheduler that time-shares one non-uniform-threshold flash ADC among N_CH analog requesters.
- Per conversion it sequences: input-mux select, settle, sample/hold pulse, conversion wait.
- It then decodes the 7-bit comparator thermometer into a 3-bit code and returns the result with a valid/ready handshake.
- Sits between the channel requesters and the ADC comparator bank plus its front-end mux.

Parameters:
- N_CH, 4, number of requesting channels (2..8).
- SETTLE_CYC, 3, mux settle cycles before sampling (>=1).
- CONV_CYC, 2, comparator resolve cycles after sampling (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  permits new grants; an in-flight conversion always completes.
- req  in  N_CH  per-channel level request; held until its grant pulse.
- gnt  out  N_CH  one-hot grant pulse, exactly one cycle per dispatched conversion.
- ch_sel  out  clog2(N_CH)  front-end mux select; stable from grant to end of CONVERT.
- sample  out  1  sample/hold strobe, one cycle.
- busy  out  1  high in any state other than IDLE.
- therm  in  7  comparator outputs; bit i = input above threshold i, ascending thresholds.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_ch  out  clog2(N_CH)  channel of the result.
- rsp_code  out  3  decoded code 0..7.
- rsp_err  out  1  bubble detected in therm.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - gnt, sample, busy, rsp_valid, rsp_err = 0; ch_sel, rsp_ch, rsp_code = 0.
  - Round-robin pointer = 0. All of the above take effect immediately, mid-conversion included.
- State machine: IDLE -> SETTLE -> SAMPLE -> CONVERT -> DONE -> IDLE.
- IDLE:
  - If en and any req, pick the winner: the first set req at or after pointer, searching upward with wrap.
  - Register ch_sel=winner, set gnt[winner]=1 for the next cycle, load counter, go to SETTLE.
  - Set pointer = winner+1 mod N_CH.
- SETTLE: lasts exactly SETTLE_CYC cycles; gnt high only in the first of them.
- SAMPLE: 1 cycle, sample=1.
- CONVERT:
  - Lasts CONV_CYC cycles.
  - On the last CONVERT cycle edge, capture therm, decode, and load rsp_*; go to DONE.
- DONE:
  - rsp_valid=1; rsp_* held stable while rsp_ready=0.
  - Transfer occurs on the edge where rsp_valid&&rsp_ready; go to IDLE and clear rsp_valid.
  - No grant is issued in the same cycle as the transfer; the next grant is evaluated in IDLE.
- Latency: with the grant cycle numbered 1, sample is in cycle 1+SETTLE_CYC and rsp_valid first asserts in cycle 2+SETTLE_CYC+CONV_CYC. Defaults: sample in cycle 4, rsp_valid in cycle 7.
- Thermometer decode:
  - Valid pattern = ones contiguous from bit0 (0000000, 0000001, ..., 1111111).
  - Valid pattern: rsp_code = popcount, rsp_err=0.
  - Any other pattern: rsp_code = popcount (saturated to 7), rsp_err=1.
- Boundary cases:
  - Requests arriving while busy are held by the requester and served later.
  - en dropping mid-conversion does not abort.
  - A req deasserted before its grant is simply skipped.
  - If no req is set, IDLE holds and the pointer is unchanged.
  - Pointer wrap: after granting channel N_CH-1, the search starts at channel 0.
- therm is sampled only at the capture edge; values at other times are ignored.

Test Plan:
- Single request: reset, req=0001, therm=0000111 -> gnt=0001 in cycle 1, sample in cycle 4, rsp_valid in cycle 7 with rsp_ch=0, rsp_code=3, rsp_err=0.
- Round-robin fairness: req=1111 held constantly with rsp_ready=1 -> grant order 0,1,2,3,0 and no channel is granted twice before the others.
- Backpressure: rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_code stable with no new gnt; rsp_ready=1 -> returns to IDLE, next gnt one cycle later.
- Decode extremes and bubble:
  - therm=0000000 -> code 0, err=0.
  - therm=1111111 -> code 7, err=0.
  - therm=0001011 -> code 3, err=1.
- en gating: drop en during SETTLE -> current conversion completes, no further gnt while en=0 with req=0010 pending; raise en -> gnt=0010.
- Async reset mid-CONVERT: rst_n low -> busy, sample, rsp_valid, gnt drop immediately; after release, req=0100 -> gnt=0100 (pointer restarted at 0).
